// File: rtl/tia_phase_gen.sv
`default_nettype none
// ============================================================================
// Module   : tia_phase_gen
// Brief    : Two-phase, non-overlapping strobe generator. Each DIV-clock
//            period it gives one phi1 strobe (D2 s1, evaluate) and one phi2
//            strobe (D2 s2, transfer). There is one phi1 to phi2 gap of DIV/2
//            clocks. The block supports freeze (en low) and a resync that
//            restarts the period. phi2 is never followed directly by phi1.
// Ports    : clk     in  1      colour clock, rising edge
//            reset_n in  1      asynchronous active-low reset
//            en      in  1      run enable; low freezes count, drops strobes
//            resync  in  1      synchronous period restart request
//            phi1    out 1      evaluate strobe (cnt==0 while running)
//            phi2    out 1      transfer strobe (cnt==DIV/2 while running)
//            phase   out CNT_W  current counter value
//            period  out 1      start-of-period pulse, same as phi1
// Params   : DIV must be even and >= 4; 2**CNT_W must be >= DIV.
// Revision : 1.0 - initial release
// ============================================================================
module tia_phase_gen #(
    parameter int DIV   = 4,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             resync,
    output logic             phi1,
    output logic             phi2,
    output logic [CNT_W-1:0] phase,
    output logic             period
);

    localparam logic [CNT_W-1:0] c_zero = '0;
    localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] c_half = CNT_W'(DIV / 2);

    logic [CNT_W-1:0] r_cnt;
    // A resync that arrives while frozen is remembered here. The first
    // enabled edge then lands on cnt==0 and does not step past it.
    logic             r_restart;
    // The strobe flops hold run & decode(cnt). Because run <= en, the
    // decode of the next count is registered together with en.
    logic             r_phi1;
    logic             r_phi2;

    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_restart_nxt;

    always_comb begin
        w_cnt_nxt     = r_cnt;
        w_restart_nxt = r_restart;
        if (!en) begin
            if (resync) begin
                w_cnt_nxt     = c_zero;
                w_restart_nxt = 1'b1;
            end
        end else if (resync || r_restart) begin
            // Restarting out of the phi2 slot must pass through one dead
            // clock (DIV-1). Otherwise phi1 would sit right after phi2.
            w_cnt_nxt     = (resync && (r_cnt == c_half)) ? c_last : c_zero;
            w_restart_nxt = 1'b0;
        end else begin
            w_cnt_nxt = (r_cnt == c_last) ? c_zero : (r_cnt + c_one);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= c_last;
            r_restart <= 1'b0;
            r_phi1    <= 1'b0;
            r_phi2    <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_restart <= w_restart_nxt;
            r_phi1    <= en && (w_cnt_nxt == c_zero);
            r_phi2    <= en && (w_cnt_nxt == c_half);
        end
    end

    assign phi1   = r_phi1;
    assign phi2   = r_phi2;
    assign period = r_phi1;
    assign phase  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tia_phase_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_tia_phase_gen
// Brief    : Directed self-checking bench for tia_phase_gen, with DIV=4 and
//            DIV=6 instances, a 6-stage D2 feedback chain and strobe monitors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tia_phase_gen;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en, resync;
    logic       phi1, phi2, period;
    logic [1:0] phase;

    logic       en6, resync6;
    logic       phi1_6, phi2_6, period6;
    logic [2:0] phase6;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tia_phase_gen #(.DIV(4), .CNT_W(2)) u_dut (
        .clk(clk), .reset_n(reset_n), .en(en), .resync(resync),
        .phi1(phi1), .phi2(phi2), .phase(phase), .period(period)
    );

    tia_phase_gen #(.DIV(6), .CNT_W(3)) u_dut6 (
        .clk(clk), .reset_n(reset_n), .en(en6), .resync(resync6),
        .phi1(phi1_6), .phi2(phi2_6), .phase(phase6), .period(period6)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [1:0] ph, input logic p1, input logic p2);
        chk({tag, "_phase"},  {30'd0, phase}, {30'd0, ph});
        chk({tag, "_phi1"},   {31'd0, phi1},  {31'd0, p1});
        chk({tag, "_phi2"},   {31'd0, phi2},  {31'd0, p2});
        chk({tag, "_period"}, {31'd0, period}, {31'd0, p1});
    endtask

    // Six D2 stages: master samples on phi1, slave transfers on phi2.
    // Inverted feedback keeps the chain toggling.
    logic [5:0] d2_m, d2_s, d2_s_prev;
    int         n_d2 = 0;
    logic       mon_on = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d2_m <= '0;
            d2_s <= '0;
        end else begin
            if (phi1) d2_m <= {d2_s[4:0], ~d2_s[5]};
            if (phi2) d2_s <= d2_m;
        end
    end

    // Strobe invariants, checked at every negative edge
    logic prev_phi2 = 1'b0;
    logic prev_phi2_6 = 1'b0;
    int   sp12 = 0, sp21 = 0;
    logic v12 = 1'b0, v21 = 1'b0;

    always @(negedge clk) begin
        chk("ovl4",  {31'd0, phi1 & phi2}, 32'd0);
        chk("p2p1_4", {31'd0, prev_phi2 & phi1}, 32'd0);
        chk("rng4",  {31'd0, phase <= 2'd3}, 32'd1);
        chk("ovl6",  {31'd0, phi1_6 & phi2_6}, 32'd0);
        chk("p2p1_6", {31'd0, prev_phi2_6 & phi1_6}, 32'd0);
        chk("rng6",  {31'd0, phase6 <= 3'd5}, 32'd1);
        if (mon_on && (d2_s != d2_s_prev)) begin
            n_d2++;
            chk("d2_upd_on_phi2", {31'd0, prev_phi2}, 32'd1);
        end
        if (!reset_n) begin
            v12 = 1'b0;
            v21 = 1'b0;
        end else if (phi1_6) begin
            if (v21) chk("div6_sp21", sp21 + 1, 3);
            sp12 = 0;
            v12  = 1'b1;
            v21  = 1'b0;
        end else if (phi2_6) begin
            if (v12) chk("div6_sp12", sp12 + 1, 3);
            sp21 = 0;
            v21  = 1'b1;
            v12  = 1'b0;
        end else begin
            sp12++;
            sp21++;
        end
        prev_phi2   = phi2;
        prev_phi2_6 = phi2_6;
        d2_s_prev   = d2_s;
    end

    logic [1:0] t1_ph [12] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    logic       t1_p1 [12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       t1_p2 [12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        reset_n = 1'b0; en = 1'b1; resync = 1'b0; en6 = 1'b1; resync6 = 1'b0;
        tick; tick;
        chk_out("rst", 2'd3, 1'b0, 1'b0);
        reset_n = 1'b1;

        // Free run after reset: phi1 on clks 1,5,9 and phi2 on clks 3,7,11
        for (int k = 0; k < 12; k++) begin
            tick;
            chk_out("run", t1_ph[k], t1_p1[k], t1_p2[k]);
        end

        // Freeze at phase 1, then resume
        tick; chk_out("pre_frz0", 2'd0, 1'b1, 1'b0);
        tick; chk_out("pre_frz1", 2'd1, 1'b0, 1'b0);
        en = 1'b0;
        repeat (3) begin tick; chk_out("frz", 2'd1, 1'b0, 1'b0); end
        en = 1'b1;
        tick; chk_out("res0", 2'd2, 1'b0, 1'b1);
        tick; chk_out("res1", 2'd3, 1'b0, 1'b0);
        tick; chk_out("res2", 2'd0, 1'b1, 1'b0);

        // Resync during phi2 passes through one dead clock
        tick; chk_out("rs2_a", 2'd1, 1'b0, 1'b0);
        tick; chk_out("rs2_b", 2'd2, 1'b0, 1'b1);
        resync = 1'b1;
        tick; chk_out("rs2_dead", 2'd3, 1'b0, 1'b0);
        resync = 1'b0;
        tick; chk_out("rs2_phi1", 2'd0, 1'b1, 1'b0);

        // Resync at phase 1 gives an immediate phi1
        tick; chk_out("rs1_a", 2'd1, 1'b0, 1'b0);
        resync = 1'b1;
        tick; chk_out("rs1_phi1", 2'd0, 1'b1, 1'b0);
        resync = 1'b0;
        tick; chk_out("rs1_b", 2'd1, 1'b0, 1'b0);
        tick; chk_out("rs1_phi2", 2'd2, 1'b0, 1'b1);

        // Resync at wrap, then at phase 0 (phi1 twice in a row)
        tick; chk_out("rsw_a", 2'd3, 1'b0, 1'b0);
        resync = 1'b1;
        tick; chk_out("rsw_wrap", 2'd0, 1'b1, 1'b0);
        tick; chk_out("rsw_again", 2'd0, 1'b1, 1'b0);
        resync = 1'b0;
        tick; chk_out("rsw_b", 2'd1, 1'b0, 1'b0);

        // Resync while frozen: phi1 on the first clock after en returns
        en = 1'b0; resync = 1'b1;
        tick; chk_out("rsf_a", 2'd0, 1'b0, 1'b0);
        resync = 1'b0;
        tick; chk_out("rsf_b", 2'd0, 1'b0, 1'b0);
        tick; chk_out("rsf_c", 2'd0, 1'b0, 1'b0);
        en = 1'b1;
        tick; chk_out("rsf_phi1", 2'd0, 1'b1, 1'b0);
        tick; chk_out("rsf_d", 2'd1, 1'b0, 1'b0);

        // Asynchronous reset while phi1 is high
        tick; chk_out("ar_a", 2'd2, 1'b0, 1'b1);
        tick; chk_out("ar_b", 2'd3, 1'b0, 1'b0);
        tick; chk_out("ar_phi1", 2'd0, 1'b1, 1'b0);
        #2 reset_n = 1'b0;
        #1 chk_out("ar_drop", 2'd3, 1'b0, 1'b0);
        en = 1'b0;
        tick;
        reset_n = 1'b1;
        tick; chk_out("ar_idle0", 2'd3, 1'b0, 1'b0);
        tick; chk_out("ar_idle1", 2'd3, 1'b0, 1'b0);
        en = 1'b1;
        tick; chk_out("ar_first", 2'd0, 1'b1, 1'b0);
        tick; chk_out("ar_next", 2'd1, 1'b0, 1'b0);

        // Random en/resync while the monitors and the D2 chain run
        mon_on = 1'b1;
        for (int i = 0; i < 200; i++) begin
            en     = ($urandom_range(0, 3) != 0);
            resync = ($urandom_range(0, 7) == 0);
            tick;
        end
        en = 1'b1; resync = 1'b0;
        repeat (8) tick;
        mon_on = 1'b0;
        chk("d2_active", {31'd0, n_d2 != 0}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
